// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter for the shared data-memory port of two cores
// Grants one access per cycle, serializes a core's write-before-read, and tags reads for return routing.
module dmem_arbiter #(
   parameter int AW     = 15,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          c0_ren,
   input  logic [AW-1:0] c0_raddr,
   input  logic          c0_wen,
   input  logic [AW-1:0] c0_waddr,
   input  logic [DW-1:0] c0_wdata,
   output logic          c0_stall,
   output logic          c0_rvalid,
   output logic [DW-1:0] c0_rdata,
   input  logic          c1_ren,
   input  logic [AW-1:0] c1_raddr,
   input  logic          c1_wen,
   input  logic [AW-1:0] c1_waddr,
   input  logic [DW-1:0] c1_wdata,
   output logic          c1_stall,
   output logic          c1_rvalid,
   output logic [DW-1:0] c1_rdata,
   output logic          mem_ren,
   output logic [AW-1:0] mem_raddr,
   output logic          mem_wen,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   logic              last_grant_q, last_grant_d;
   logic [1:0]        wr_done_q, wr_done_d;
   logic [1:0]        ren, wen_eff, req, gnt, is_final;
   logic [RD_LAT-1:0] tag_v_q, tag_o_q;
   logic [1:0]        rvalid_q;
   logic [DW-1:0]     rdata0_q, rdata1_q;

   always_comb begin
      ren      = {c1_ren, c0_ren};
      // once a core's write has gone out, its still-asserted wen must not win again
      wen_eff  = {c1_wen, c0_wen} & ~wr_done_q;
      req      = ren | wen_eff;
      gnt[0]   = rst_n & req[0] & (~req[1] | last_grant_q);
      gnt[1]   = rst_n & req[1] & (~req[0] | ~last_grant_q);
      is_final = ~wen_eff | ~ren;
      c0_stall = rst_n & req[0] & ~(gnt[0] & is_final[0]);
      c1_stall = rst_n & req[1] & ~(gnt[1] & is_final[1]);

      mem_ren   = 1'b0;
      mem_raddr = '0;
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (gnt[0]) begin
         if (wen_eff[0]) begin
            mem_wen   = 1'b1;
            mem_waddr = c0_waddr;
            mem_wdata = c0_wdata;
         end else begin
            mem_ren   = 1'b1;
            mem_raddr = c0_raddr;
         end
      end else if (gnt[1]) begin
         if (wen_eff[1]) begin
            mem_wen   = 1'b1;
            mem_waddr = c1_waddr;
            mem_wdata = c1_wdata;
         end else begin
            mem_ren   = 1'b1;
            mem_raddr = c1_raddr;
         end
      end

      last_grant_d = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last_grant_q);
      wr_done_d    = wr_done_q;
      for (int i = 0; i < 2; i++) begin
         if (gnt[i]) wr_done_d[i] = wen_eff[i] & ren[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         wr_done_q    <= '0;
         tag_v_q      <= '0;
         tag_o_q      <= '0;
         rvalid_q     <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wr_done_q    <= wr_done_d;
         tag_v_q[0]   <= mem_ren;
         tag_o_q[0]   <= gnt[1];
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v_q[i] <= tag_v_q[i-1];
            tag_o_q[i] <= tag_o_q[i-1];
         end
         // tail entry lines up with mem_rdata; register it toward its owner only
         rvalid_q[0] <= tag_v_q[RD_LAT-1] & ~tag_o_q[RD_LAT-1];
         rvalid_q[1] <= tag_v_q[RD_LAT-1] & tag_o_q[RD_LAT-1];
         if (tag_v_q[RD_LAT-1] && !tag_o_q[RD_LAT-1]) rdata0_q <= mem_rdata;
         if (tag_v_q[RD_LAT-1] && tag_o_q[RD_LAT-1])  rdata1_q <= mem_rdata;
      end
   end

   assign c0_rvalid = rvalid_q[0];
   assign c1_rvalid = rvalid_q[1];
   assign c0_rdata  = rdata0_q;
   assign c1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter at RD_LAT=1 (inst 0) and RD_LAT=3 (inst 1)
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        c0_ren [2];
   logic [14:0] c0_raddr [2];
   logic        c0_wen [2];
   logic [14:0] c0_waddr [2];
   logic [15:0] c0_wdata [2];
   logic        c0_stall [2];
   logic        c0_rvalid [2];
   logic [15:0] c0_rdata [2];
   logic        c1_ren [2];
   logic [14:0] c1_raddr [2];
   logic        c1_wen [2];
   logic [14:0] c1_waddr [2];
   logic [15:0] c1_wdata [2];
   logic        c1_stall [2];
   logic        c1_rvalid [2];
   logic [15:0] c1_rdata [2];
   logic        mem_ren [2];
   logic [14:0] mem_raddr [2];
   logic        mem_wen [2];
   logic [14:0] mem_waddr [2];
   logic [15:0] mem_wdata [2];
   logic [15:0] mem_rdata [2];

   int cyc;
   int checks;
   int errors;

   typedef struct packed {
      logic [1:0]  inst;
      logic        ren;
      logic        wen;
      logic [14:0] raddr;
      logic [14:0] waddr;
      logic [15:0] wdata;
      logic        s0;
      logic        s1;
   } cmd_t;

   typedef struct packed {
      logic        core;
      logic [15:0] data;
      logic [31:0] due;
   } rd_t;

   cmd_t cmd_q [$];
   rd_t  rd_q0 [$];
   rd_t  rd_q1 [$];

   function automatic logic [15:0] init_val(input logic [14:0] a);
      return {6'h2A, a[9:0]};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = (g == 1) ? 3 : 1;
      logic [15:0] mem [0:1023];
      logic [15:0] rpipe [LAT];

      dmem_arbiter #(.AW(15), .DW(16), .RD_LAT(LAT)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .c0_ren    (c0_ren[g]),
         .c0_raddr  (c0_raddr[g]),
         .c0_wen    (c0_wen[g]),
         .c0_waddr  (c0_waddr[g]),
         .c0_wdata  (c0_wdata[g]),
         .c0_stall  (c0_stall[g]),
         .c0_rvalid (c0_rvalid[g]),
         .c0_rdata  (c0_rdata[g]),
         .c1_ren    (c1_ren[g]),
         .c1_raddr  (c1_raddr[g]),
         .c1_wen    (c1_wen[g]),
         .c1_waddr  (c1_waddr[g]),
         .c1_wdata  (c1_wdata[g]),
         .c1_stall  (c1_stall[g]),
         .c1_rvalid (c1_rvalid[g]),
         .c1_rdata  (c1_rdata[g]),
         .mem_ren   (mem_ren[g]),
         .mem_raddr (mem_raddr[g]),
         .mem_wen   (mem_wen[g]),
         .mem_waddr (mem_waddr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g])
      );

      initial begin
         for (int a = 0; a < 1024; a++) mem[a] = init_val(15'(a));
      end

      always @(posedge clk) begin
         if (mem_wen[g]) mem[mem_waddr[g][9:0]] <= mem_wdata[g];
         rpipe[0] <= mem[mem_raddr[g][9:0]];
         for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
      end

      assign mem_rdata[g] = rpipe[LAT-1];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int g = 0; g < 2; g++) begin
         c0_ren[g] = 0; c0_raddr[g] = '0; c0_wen[g] = 0; c0_waddr[g] = '0; c0_wdata[g] = '0;
         c1_ren[g] = 0; c1_raddr[g] = '0; c1_wen[g] = 0; c1_waddr[g] = '0; c1_wdata[g] = '0;
      end
   endtask

   task automatic exp_cmd(input int g, input logic ren, input logic wen, input logic [14:0] ra,
                          input logic [14:0] wa, input logic [15:0] wd, input logic s0, input logic s1);
      cmd_q.push_back({2'(g), ren, wen, ra, wa, wd, s0, s1});
   endtask

   task automatic exp_rd(input int g, input logic core, input logic [15:0] d);
      if (g == 0) rd_q0.push_back({core, d, 32'(cyc + 2)});
      else        rd_q1.push_back({core, d, 32'(cyc + 4)});
   endtask

   // per-cycle command monitor and read-return scoreboard
   always @(negedge clk) begin
      cmd_t c;
      rd_t  r;
      if (cmd_q.size() > 0) begin
         c = cmd_q.pop_front();
         chk("mem_ren",   32'(mem_ren[c.inst]),   32'(c.ren));
         chk("mem_wen",   32'(mem_wen[c.inst]),   32'(c.wen));
         chk("mem_raddr", 32'(mem_raddr[c.inst]), 32'(c.raddr));
         chk("mem_waddr", 32'(mem_waddr[c.inst]), 32'(c.waddr));
         chk("mem_wdata", 32'(mem_wdata[c.inst]), 32'(c.wdata));
         chk("c0_stall",  32'(c0_stall[c.inst]),  32'(c.s0));
         chk("c1_stall",  32'(c1_stall[c.inst]),  32'(c.s1));
      end
      for (int g = 0; g < 2; g++) begin
         if (c0_rvalid[g] || c1_rvalid[g]) begin
            chk("rvalid_both", 32'(c0_rvalid[g] & c1_rvalid[g]), 32'd0);
            if ((g == 0 && rd_q0.size() == 0) || (g == 1 && rd_q1.size() == 0)) begin
               chk("rvalid_unexpected", {30'd0, c1_rvalid[g], c0_rvalid[g]}, 32'd0);
            end else begin
               r = (g == 0) ? rd_q0.pop_front() : rd_q1.pop_front();
               chk("rv_core", 32'(c1_rvalid[g]), 32'(r.core));
               chk("rv_data", 32'(r.core ? c1_rdata[g] : c0_rdata[g]), 32'(r.data));
               chk("rv_cycle", 32'(cyc), r.due);
            end
         end
      end
   end

   initial begin
      idle_all();
      rst_n = 1'b0;
      step();
      // requests during reset must be masked
      c0_ren[0] = 1; c0_raddr[0] = 15'h0011; c1_wen[0] = 1; c1_waddr[0] = 15'h0022;
      exp_cmd(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      rst_n = 1'b1;
      idle_all();
      for (int g = 0; g < 2; g++) begin
         chk("reset_c0_rvalid", 32'(c0_rvalid[g]), 32'd0);
         chk("reset_c1_rvalid", 32'(c1_rvalid[g]), 32'd0);
         chk("reset_c0_rdata",  32'(c0_rdata[g]),  32'd0);
         chk("reset_c1_rdata",  32'(c1_rdata[g]),  32'd0);
      end

      // lone c0 read
      c0_ren[0] = 1; c0_raddr[0] = 15'h0010;
      exp_cmd(0, 1, 0, 15'h0010, 0, 0, 0, 0);
      exp_rd(0, 0, 16'hA810);
      step();
      c0_ren[0] = 0;
      exp_cmd(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      exp_cmd(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();

      // continuous write contention after reset: c0,c1,c0,...
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         c0_wen[0] = 1; c0_waddr[0] = 15'h0100; c0_wdata[0] = 16'h1111;
         c1_wen[0] = 1; c1_waddr[0] = 15'h0200; c1_wdata[0] = 16'h2222;
         if (i % 2 == 0) exp_cmd(0, 0, 1, 0, 15'h0100, 16'h1111, 0, 1);
         else            exp_cmd(0, 0, 1, 0, 15'h0200, 16'h2222, 1, 0);
         step();
      end
      idle_all();
      exp_cmd(0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // c1 write+read same address
      c1_ren[0] = 1; c1_wen[0] = 1; c1_raddr[0] = 15'h0040; c1_waddr[0] = 15'h0040; c1_wdata[0] = 16'hBEEF;
      exp_cmd(0, 0, 1, 0, 15'h0040, 16'hBEEF, 0, 1);
      step();
      exp_cmd(0, 1, 0, 15'h0040, 0, 0, 0, 0);
      exp_rd(0, 1, 16'hBEEF);
      step();
      idle_all();
      exp_cmd(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      step();

      // last_grant survives idle cycles
      c0_ren[0] = 1; c0_raddr[0] = 15'h0004;
      exp_cmd(0, 1, 0, 15'h0004, 0, 0, 0, 0);
      exp_rd(0, 0, init_val(15'h0004));
      step();
      c0_ren[0] = 0; c1_ren[0] = 1; c1_raddr[0] = 15'h0005;
      exp_cmd(0, 1, 0, 15'h0005, 0, 0, 0, 0);
      exp_rd(0, 1, init_val(15'h0005));
      step();
      idle_all();
      step();
      step();
      c0_ren[0] = 1; c0_raddr[0] = 15'h0006; c1_ren[0] = 1; c1_raddr[0] = 15'h0007;
      exp_cmd(0, 1, 0, 15'h0006, 0, 0, 0, 1);
      exp_rd(0, 0, init_val(15'h0006));
      step();
      c0_ren[0] = 0;
      exp_cmd(0, 1, 0, 15'h0007, 0, 0, 0, 0);
      exp_rd(0, 1, init_val(15'h0007));
      step();
      idle_all();
      step();
      step();
      step();

      // RD_LAT=3 alternating reads
      c0_ren[1] = 1; c0_raddr[1] = 15'h0001;
      exp_cmd(1, 1, 0, 15'h0001, 0, 0, 0, 0);
      exp_rd(1, 0, init_val(15'h0001));
      step();
      c0_ren[1] = 0; c1_ren[1] = 1; c1_raddr[1] = 15'h0002;
      exp_cmd(1, 1, 0, 15'h0002, 0, 0, 0, 0);
      exp_rd(1, 1, init_val(15'h0002));
      step();
      c1_ren[1] = 0; c0_ren[1] = 1; c0_raddr[1] = 15'h0003;
      exp_cmd(1, 1, 0, 15'h0003, 0, 0, 0, 0);
      exp_rd(1, 0, init_val(15'h0003));
      step();
      idle_all();
      for (int i = 0; i < 6; i++) step();

      // reset with reads in flight: c1 then c0 granted, then reset
      c1_ren[1] = 1; c1_raddr[1] = 15'h0008;
      exp_cmd(1, 1, 0, 15'h0008, 0, 0, 0, 0);
      step();
      c1_ren[1] = 0; c0_ren[1] = 1; c0_raddr[1] = 15'h0009;
      exp_cmd(1, 1, 0, 15'h0009, 0, 0, 0, 0);
      step();
      rst_n = 1'b0;
      c0_ren[1] = 1; c0_raddr[1] = 15'h000A; c1_ren[1] = 1; c1_raddr[1] = 15'h000B;
      exp_cmd(1, 0, 0, 0, 0, 0, 0, 0);
      step();
      rst_n = 1'b1;
      exp_cmd(1, 1, 0, 15'h000A, 0, 0, 0, 1);
      exp_rd(1, 0, init_val(15'h000A));
      step();
      c0_ren[1] = 0;
      exp_cmd(1, 1, 0, 15'h000B, 0, 0, 0, 0);
      exp_rd(1, 1, init_val(15'h000B));
      step();
      idle_all();

      for (int n = 0; n < 20 && (rd_q0.size() + rd_q1.size()) > 0; n++) step();
      step();
      chk("drain_pending_reads", 32'(rd_q0.size() + rd_q1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-core arbiter for the shared memory's single data port (read address / write enable / write data).
- Sits between core1/core2 data-side outputs and mem.
- Replaces the fixed top-level stall-count heuristic with cycle-accurate round-robin grants, per-core stall signals and tagged read-data return.
- Instruction fetch ports bypass this block.

Parameters:
- AW, 15, word address width (byte address bits [15:1]).
- DW, 16, data width.
- RD_LAT, 1, mem read latency in cycles from mem_ren to mem_rdata valid; legal 1..4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- c0_ren  in  1  core 0 read request
- c0_raddr  in  AW  core 0 read word address
- c0_wen  in  1  core 0 write request
- c0_waddr  in  AW  core 0 write word address
- c0_wdata  in  DW  core 0 write data
- c0_stall  out  1  core 0 must hold its request and freeze
- c0_rvalid  out  1  core 0 read data valid
- c0_rdata  out  DW  core 0 read data
- c1_* (ren, raddr, wen, waddr, wdata, stall, rvalid, rdata): identical set for core 1
- mem_ren  out  1  memory read strobe
- mem_raddr  out  AW  memory read address
- mem_wen  out  1  memory write strobe
- mem_waddr  out  AW  memory write address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, RD_LAT cycles after mem_ren

Behaviour:
- Interface: one clock, `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - last_grant<=1, so core 0 wins the first tie.
  - Per-core wr_done<=0; tag pipeline cleared.
  - c*_rvalid<=0, c*_rdata<=0.
  - While rst_n=0, all mem_* strobes and c*_stall are forced 0.
- Request: req_i = ci_ren | ci_wen.
  - Each cycle at most one access (read or write) goes to mem.
  - A core holds all request inputs stable while its stall is high.
- Per-core sub-order: if a core asserts ren and wen together, the write is served first and the read in a later grant.
  - wr_done_i is set when that write is granted and ren is still pending.
  - wr_done_i is cleared when the read is granted.
  - While wr_done_i=1, the core's wen is ignored.
- Grant (combinational from current inputs and state):
  - Only one requester: it wins.
  - Both requesting: the core != last_grant wins.
  - last_grant updates to the winner at the clock edge; it is unchanged when there is no grant.
- Command outputs (combinational, same cycle as grant):
  - Granted write: mem_wen=1 with that core's waddr/wdata, mem_ren=0.
  - Granted read: mem_ren=1 with that core's raddr, mem_wen=0.
  - Never both strobes in one cycle.
  - Address/data outputs are 0 when not driven.
- Stall: ci_stall = req_i & ~(granted_i & access_is_final_i).
  - access_is_final is 1 for a read, for a write with ren=0, or for a read following wr_done.
  - A core with ren & wen therefore stalls for at least 1 cycle even when uncontended.
- Read return: an RD_LAT-deep shift register of {valid, owner} captures each granted read.
  - When the tail entry is valid, mem_rdata is registered into the owner's c*_rdata on the next edge and that core's rvalid pulses for 1 cycle.
  - Total read latency = RD_LAT+1 cycles from grant; the other core's rdata holds its previous value.
- Back-to-back reads from alternating cores are supported every cycle; the tag pipeline never stalls.
- Same-address write then read: order of service equals memory order, so the read sees the new data. No forwarding is required.
- Reset mid-read: in-flight tags are discarded, no rvalid is produced, and late mem_rdata is ignored.
- Bandwidth: sustained throughput is 1 access/cycle; under continuous contention, grants alternate strictly.

Test Plan:
1. Reset, then c0 read of 0x0010 alone → same cycle mem_ren=1, mem_raddr=0x0010, c0_stall=0; with RD_LAT=1, c0_rvalid=1 two cycles after grant with c0_rdata=mem value; c1_rvalid stays 0.
2. Both cores write every cycle for 6 cycles (c0 to 0x0100, c1 to 0x0200) → grants alternate c0,c1,c0,…; each core's stall is 1 on alternate cycles; exactly 6 mem_wen pulses; no cycle with both mem strobes.
3. c1 asserts ren=1 and wen=1 together (waddr=raddr=0x0040, wdata=0xBEEF), c0 idle → cycle 0: write, c1_stall=1; cycle 1: read, c1_stall=0; c1_rdata=0xBEEF at RD_LAT+1 cycles after cycle 1.
4. RD_LAT=3 with alternating reads c0 0x1, c1 0x2, c0 0x3 on consecutive cycles → rvalid pulses return in the same order on consecutive cycles, each routed to the correct core.
5. rst_n=0 for one cycle while two reads are in flight → no rvalid afterwards; last_grant=1, so a subsequent tie goes to c0.
6. Tie after c1 wins a single-requester cycle → next tie goes to c0 (last_grant honoured across idle cycles).
